// File: rtl/ras_pkg.sv
// Shared constants, action field layout and helpers for the speculative RAS pipeline.
package ras_pkg;

  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 10;

  // Packed action layout, MSB to LSB: {data, addr, pop, push}
  localparam int unsigned ACT_PUSH_BIT = 0;
  localparam int unsigned ACT_POP_BIT  = 1;
  localparam int unsigned ACT_ADDR_LSB = 2;

  typedef enum logic [1:0] {
    ACT_NOP      = 2'b00,
    ACT_PUSH     = 2'b01,
    ACT_POP      = 2'b10,
    ACT_POP_PUSH = 2'b11
  } act_kind_e;

  function automatic int unsigned act_width(input int unsigned data_w,
                                            input int unsigned addr_w);
    return data_w + addr_w + 2;
  endfunction

  function automatic int unsigned act_data_lsb(input int unsigned addr_w);
    return addr_w + ACT_ADDR_LSB;
  endfunction

  function automatic logic kind_has_push(input act_kind_e kind);
    return (kind == ACT_PUSH) || (kind == ACT_POP_PUSH);
  endfunction

  function automatic logic kind_has_pop(input act_kind_e kind);
    return (kind == ACT_POP) || (kind == ACT_POP_PUSH);
  endfunction

endpackage

// File: rtl/ras_bram.sv
// Simple dual-port RAM, one write and one registered read port, write-first on collision.
module ras_bram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Contents are deliberately never reset so they survive squash and reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ras_fifo_cnt.sv
// Show-ahead FIFO with occupancy count and synchronous clear; empty head reads as zero.
module ras_fifo_cnt #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 44
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clear_i,
  input  logic                       wr_en_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       rd_en_i,
  output logic [W-1:0]               rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr, do_rd, clr;

  assign clr   = reset_i | clear_i;
  assign do_wr = wr_en_i & ~full_o & ~clr;
  assign do_rd = rd_en_i & ~empty_o & ~clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk_i) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ras_spec_stage.sv
// Speculative RAS successor stage: pending-action queue, scratchpad, visible/masked push counters.
module ras_spec_stage
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               trigger,
  input  logic                               pop_i,
  input  logic                               push_i,
  input  logic [WIDTH-1:0]                   data_i,
  input  logic [ADDR_WIDTH-1:0]              addr_i,
  output logic                               ready,
  input  logic                               commit,
  input  logic                               flush,
  output logic                               valid_o,
  output logic                               pop_o,
  output logic                               push_o,
  output logic [WIDTH-1:0]                   data_o,
  output logic [ADDR_WIDTH-1:0]              addr_o,
  input  logic [ADDR_WIDTH-1:0]              addr,
  output logic [WIDTH-1:0]                   dout,
  output logic [ADDR_WIDTH-1:0]              base_addr,
  output logic                               valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    occupancy
);

  localparam int unsigned ADDR = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW   = act_width(WIDTH, ADDR_WIDTH);
  localparam int unsigned DLSB = act_data_lsb(ADDR_WIDTH);

  logic                  clr, acc, cm;
  act_kind_e             in_kind;
  logic                  push_acc, pop_vis, cm_push;
  logic [AW-1:0]         act_wr, act_head;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_cnt;
  logic [CW-1:0]         v_q, v_d;
  logic [CW-1:0]         m_q, m_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;

  // Ready comes from the registered count, so a commit this cycle cannot free a slot early.
  assign clr     = reset | flush;
  assign ready   = ~fifo_full;
  assign acc     = trigger & ready & ~clr;
  assign cm      = commit & valid_o & ~clr;
  assign in_kind = act_kind_e'({pop_i, push_i});
  assign act_wr  = {data_i, addr_i, pop_i, push_i};

  ras_fifo_cnt #(
    .DEPTH (FIFO_DEPTH),
    .W     (AW)
  ) u_fifo (
    .clk_i     (clk),
    .reset_i   (reset),
    .clear_i   (flush),
    .wr_en_i   (acc),
    .wr_data_i (act_wr),
    .rd_en_i   (cm),
    .rd_data_o (act_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt)
  );

  assign valid_o   = ~fifo_empty;
  assign occupancy = fifo_cnt;
  assign push_o    = act_head[ACT_PUSH_BIT];
  assign pop_o     = act_head[ACT_POP_BIT];
  assign addr_o    = act_head[DLSB-1:ACT_ADDR_LSB];
  assign data_o    = act_head[AW-1:DLSB];

  ras_bram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_scratch (
    .clk_i   (clk),
    .we_i    (push_acc),
    .waddr_i (addr_i[ADDR-1:0]),
    .wdata_i (data_i),
    .raddr_i (addr[ADDR-1:0]),
    .rdata_o (dout)
  );

  // A pop only masks a push when one is visible; the pop of a pop+push sees the old V.
  always_comb begin
    push_acc = acc & kind_has_push(in_kind);
    pop_vis  = acc & kind_has_pop(in_kind) & (v_q != '0);
    cm_push  = cm & push_o;
    v_d      = v_q;
    m_d      = m_q;
    if (clr) begin
      v_d = '0;
      m_d = '0;
    end else begin
      v_d = v_q + CW'(push_acc) - CW'(pop_vis) - CW'(cm_push & (m_q == '0));
      m_d = m_q + CW'(pop_vis) - CW'(cm_push & (m_q != '0));
    end
  end

  always_comb begin
    base_d = base_q;
    if (clr) begin
      base_d = addr;
    end else if (acc) begin
      base_d = addr_i;
    end
  end

  always_ff @(posedge clk) begin
    v_q    <= v_d;
    m_q    <= m_d;
    base_q <= base_d;
  end

  assign valid     = (v_q != '0);
  assign base_addr = base_q;

endmodule

// File: tb/tb_ras_spec_stage.sv
// Randomized and directed bench for ras_spec_stage against a queue-based reference model.
module tb_ras_spec_stage;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned FD    = 16;
  localparam int unsigned W     = 32;
  localparam int unsigned AWD   = 10;
  localparam int unsigned CW    = 5;

  logic           clk = 1'b0;
  logic           reset, trigger, pop_i, push_i, commit, flush;
  logic [W-1:0]   data_i;
  logic [AWD-1:0] addr_i, addr;
  logic           ready, valid_o, pop_o, push_o, valid;
  logic [W-1:0]   data_o, dout;
  logic [AWD-1:0] addr_o, base_addr;
  logic [CW-1:0]  occupancy;

  always #5 clk = ~clk;

  ras_spec_stage #(
    .DEPTH      (DEPTH),
    .FIFO_DEPTH (FD),
    .WIDTH      (W),
    .ADDR_WIDTH (AWD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .trigger   (trigger),
    .pop_i     (pop_i),
    .push_i    (push_i),
    .data_i    (data_i),
    .addr_i    (addr_i),
    .ready     (ready),
    .commit    (commit),
    .flush     (flush),
    .valid_o   (valid_o),
    .pop_o     (pop_o),
    .push_o    (push_o),
    .data_o    (data_o),
    .addr_o    (addr_o),
    .addr      (addr),
    .dout      (dout),
    .base_addr (base_addr),
    .valid     (valid),
    .occupancy (occupancy)
  );

  typedef struct {
    logic [W-1:0]   d;
    logic [AWD-1:0] a;
    bit             pop;
    bit             push;
  } act_t;

  act_t           mq[$];
  int             mv, mm;
  logic [AWD-1:0] mbase;
  logic [W-1:0]   mscr [DEPTH];
  bit             mknown [DEPTH];
  int             n_checks = 0;
  int             n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic compare_all(input logic [AWD-1:0] ra);
    int ridx;
    ridx = int'(ra % DEPTH);
    check("ready", 64'(ready), 64'(mq.size() < FD));
    check("valid_o", 64'(valid_o), 64'(mq.size() != 0));
    check("occupancy", 64'(occupancy), 64'(mq.size()));
    check("valid", 64'(valid), 64'(mv != 0));
    check("base_addr", 64'(base_addr), 64'(mbase));
    if (mq.size() != 0) begin
      check("push_o", 64'(push_o), 64'(mq[0].push));
      check("pop_o", 64'(pop_o), 64'(mq[0].pop));
      check("data_o", 64'(data_o), 64'(mq[0].d));
      check("addr_o", 64'(addr_o), 64'(mq[0].a));
    end else begin
      check("head_zero", {31'd0, push_o, pop_o, data_o}, 64'd0);
      check("addr_o_zero", 64'(addr_o), 64'd0);
    end
    if (mknown[ridx]) check("dout", 64'(dout), 64'(mscr[ridx]));
  endtask

  // One clock cycle: drive, advance model by the stage rules, compare.
  task automatic cyc(input bit trg, input bit po, input bit pu, input logic [W-1:0] d,
                     input logic [AWD-1:0] a, input bit cmt, input bit fl, input bit rs,
                     input logic [AWD-1:0] ra);
    bit acc, cm, pe, hp;
    trigger = trg; pop_i = po; push_i = pu; data_i = d; addr_i = a;
    commit = cmt; flush = fl; reset = rs; addr = ra;
    acc = trg && (mq.size() < FD) && !fl && !rs;
    cm  = cmt && (mq.size() != 0) && !fl && !rs;
    @(posedge clk);
    #1;
    if (rs || fl) begin
      mq.delete();
      mv = 0;
      mm = 0;
      mbase = ra;
    end else begin
      hp = 1'b0;
      if (cm) hp = mq[0].push;
      pe = acc && po && (mv != 0);
      mv = mv + int'(acc && pu) - int'(pe) - int'(hp && (mm == 0));
      mm = mm + int'(pe) - int'(hp && (mm != 0));
      if (cm) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{d: d, a: a, pop: po, push: pu});
        mbase = a;
      end
    end
    if (acc && pu) begin
      mscr[int'(a % DEPTH)]   = d;
      mknown[int'(a % DEPTH)] = 1'b1;
    end
    compare_all(ra);
  endtask

  task automatic idle(input logic [AWD-1:0] ra);
    cyc(0, 0, 0, '0, '0, 0, 0, 0, ra);
  endtask

  task automatic act(input bit po, input bit pu, input logic [W-1:0] d, input logic [AWD-1:0] a);
    cyc(1, po, pu, d, a, 0, 0, 0, '0);
  endtask

  task automatic do_commit();
    cyc(0, 0, 0, '0, '0, 1, 0, 0, '0);
  endtask

  initial begin
    cyc(0, 0, 0, '0, '0, 0, 0, 1, 10'h5);
    check("rst_base", 64'(base_addr), 64'h5);

    // Single push, then read back through the scratchpad.
    cyc(1, 0, 1, 32'hA0, 10'd3, 0, 0, 0, 10'd0);
    check("push_data_o", 64'(data_o), 64'hA0);
    idle(10'd3);
    idle(10'd3);
    check("dout_a0", 64'(dout), 64'hA0);
    do_commit();

    // push, push, pop then three commits.
    act(0, 1, 32'h11, 10'd1);
    act(0, 1, 32'h22, 10'd2);
    act(1, 0, 32'h0, 10'd2);
    check("v_after_pop", 64'(valid), 64'd1);
    repeat (3) do_commit();
    check("drained_valid", 64'(valid), 64'd0);

    // Fill with no-ops, drop a 17th, then commit+trigger while full.
    for (int i = 0; i < 16; i++) act(0, 0, '0, AWD'(i));
    check("full_ready", 64'(ready), 64'd0);
    act(0, 1, 32'hDEAD, 10'd7);
    cyc(1, 0, 1, 32'hBEEF, 10'd8, 1, 0, 0, 10'd0);
    check("occ15", 64'(occupancy), 64'd15);
    cyc(0, 0, 0, '0, '0, 0, 1, 0, 10'h2A);

    // Pop+push with V=2 and with V=0.
    act(0, 1, 32'h1, 10'd4);
    act(0, 1, 32'h2, 10'd5);
    act(1, 1, 32'h3, 10'd6);
    cyc(0, 0, 0, '0, '0, 0, 1, 0, 10'h0);
    act(1, 1, 32'h4, 10'd9);
    check("poppush_v0", 64'(valid), 64'd1);

    // Flush together with trigger and commit at occupancy 5.
    for (int i = 0; i < 4; i++) act(i[0], 1, 32'h100 + i, AWD'(i + 10));
    check("occ5", 64'(occupancy), 64'd5);
    cyc(1, 0, 1, 32'h999, 10'd12, 1, 1, 0, 10'd13);
    idle(10'd9);

    // Same-index write and read in one cycle, then reset mid-stream at occupancy 7.
    cyc(1, 0, 1, 32'hC0FFEE, 10'd14, 0, 0, 0, 10'd14);
    check("wr_first", 64'(dout), 64'hC0FFEE);
    for (int i = 0; i < 6; i++) act(0, 1, $urandom, AWD'($urandom));
    check("occ7", 64'(occupancy), 64'd7);
    cyc(1, 1, 1, 32'h5, 10'd5, 1, 0, 1, 10'h3FF);
    idle(10'd14);

    // Random phases with varied trigger/commit pressure.
    for (int p = 0; p < 6; p++) begin
      int pt, pc;
      pt = (p % 3 == 0) ? 90 : (p % 3 == 1) ? 30 : 60;
      pc = (p % 3 == 0) ? 20 : (p % 3 == 1) ? 85 : 55;
      for (int n = 0; n < 400; n++) begin
        cyc($urandom_range(99) < pt, $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom,
            AWD'($urandom), $urandom_range(99) < pc, $urandom_range(99) < 2,
            $urandom_range(199) == 0, AWD'($urandom));
      end
    end

    idle('0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
